// File: rtl/multi_tick_generator.sv
// multi_tick_generator: per-channel programmable periodic one-cycle strobes and 50% square waves
// Ports: clk, reset (async, active-high), enable[CHANNELS] run enables,
//        wr_en/wr_ch/wr_period period write, sync (only with TICK_SYNC_EN),
//        tick_pulse/tick_level per-channel registered outputs, tick_any registered OR of pulses.
// Optional feature macro: TICK_SYNC_EN adds the sync port for phase-coherent restart of all channels.
module multi_tick_generator #(
    parameter int CHANNELS       = 4,
    parameter int CNT_WIDTH      = 32,
    parameter int DEFAULT_PERIOD = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CHANNELS-1:0]  enable,
    input  logic                 wr_en,
    input  logic [3:0]           wr_ch,
    input  logic [CNT_WIDTH-1:0] wr_period,
`ifdef TICK_SYNC_EN
    input  logic                 sync,
`endif
    output logic [CHANNELS-1:0]  tick_pulse,
    output logic [CHANNELS-1:0]  tick_level,
    output logic                 tick_any
);
    logic [CNT_WIDTH-1:0] period_q [CHANNELS];
    logic [CNT_WIDTH-1:0] period_d [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_q    [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_d    [CHANNELS];
    logic [CHANNELS-1:0]  pulse_q, pulse_d, level_q, level_d;
    logic                 any_q, any_d;
    logic                 sync_hit;

`ifdef TICK_SYNC_EN
    assign sync_hit = sync;
`else
    assign sync_hit = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            period_d[i] = period_q[i];
            cnt_d[i]    = cnt_q[i] + CNT_WIDTH'(1);
            pulse_d[i]  = 1'b0;
            level_d[i]  = level_q[i];
            if (sync_hit) begin
                cnt_d[i]   = '0;
                level_d[i] = 1'b0;
            end else if (wr_en && wr_ch == 4'(i)) begin
                // a write wins over a coincident expiry, so no pulse this edge
                period_d[i] = wr_period;
                cnt_d[i]    = '0;
            end else if (!enable[i] || period_q[i] == '0) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == period_q[i] - CNT_WIDTH'(1)) begin
                cnt_d[i]   = '0;
                pulse_d[i] = 1'b1;
                level_d[i] = ~level_q[i];
            end
        end
        any_d = |pulse_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                period_q[i] <= CNT_WIDTH'(DEFAULT_PERIOD);
                cnt_q[i]    <= '0;
            end
            pulse_q <= '0;
            level_q <= '0;
            any_q   <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                period_q[i] <= period_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            pulse_q <= pulse_d;
            level_q <= level_d;
            any_q   <= any_d;
        end
    end

    assign tick_pulse = pulse_q;
    assign tick_level = level_q;
    assign tick_any   = any_q;
endmodule

// File: tb/tb_multi_tick_generator.sv
// tb_multi_tick_generator: scoreboard bench for multi_tick_generator against an edge-arithmetic reference model
module tb_multi_tick_generator;
    localparam int CH = 4;
    localparam int W  = 8;
    localparam int DP = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CH-1:0] enable = '0;
    logic          wr_en = 1'b0;
    logic [3:0]    wr_ch = '0;
    logic [W-1:0]  wr_period = '0;
`ifdef TICK_SYNC_EN
    logic          sync = 1'b0;
`endif
    logic [CH-1:0] tick_pulse, tick_level;
    logic          tick_any;

    multi_tick_generator #(.CHANNELS(CH), .CNT_WIDTH(W), .DEFAULT_PERIOD(DP)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .wr_en(wr_en),
        .wr_ch(wr_ch),
        .wr_period(wr_period),
`ifdef TICK_SYNC_EN
        .sync(sync),
`endif
        .tick_pulse(tick_pulse),
        .tick_level(tick_level),
        .tick_any(tick_any)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [2*CH:0] exp_q[$];

    // Model: a channel fires at edge e when it has been running uninterrupted
    // since restart edge s and (e - s) is a multiple of its period.
    longint edge_n = 0;
    longint start_edge [CH];
    int     per [CH];
    bit     lvl [CH];

    task automatic model_edge();
        logic [CH-1:0] p = '0;
        logic [CH-1:0] l = '0;
        edge_n++;
        for (int i = 0; i < CH; i++) begin
            bit sy = 1'b0;
`ifdef TICK_SYNC_EN
            sy = sync;
`endif
            if (reset) begin
                per[i] = DP; start_edge[i] = edge_n; lvl[i] = 1'b0;
            end else if (sy) begin
                start_edge[i] = edge_n; lvl[i] = 1'b0;
            end else if (wr_en && int'(wr_ch) == i) begin
                per[i] = int'(wr_period); start_edge[i] = edge_n;
            end else if (!enable[i] || per[i] == 0) begin
                start_edge[i] = edge_n;
            end else if ((edge_n - start_edge[i]) % per[i] == 0) begin
                p[i] = 1'b1; lvl[i] = ~lvl[i];
            end
            l[i] = lvl[i];
        end
        exp_q.push_back({|p, l, p});
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            wr_en = 1'b0;
`ifdef TICK_SYNC_EN
            sync = 1'b0;
`endif
        end
    endtask

    task automatic wr(int ch, int p);
        wr_en = 1'b1; wr_ch = 4'(ch); wr_period = W'(p);
    endtask

    task automatic async_reset_check();
        reset = 1'b1;
        #1;
        tests++;
        if ({tick_any, tick_level, tick_pulse} !== '0) begin
            fails++;
            $display("FAIL async_reset: got %b required 0", {tick_any, tick_level, tick_pulse});
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [2*CH:0] e;
            e = exp_q.pop_front();
            tests++;
            if ({tick_any, tick_level, tick_pulse} !== e) begin
                fails++;
                $display("FAIL outputs @edge %0d: got any=%b lvl=%b pls=%b required any=%b lvl=%b pls=%b",
                         edge_n, tick_any, tick_level, tick_pulse, e[2*CH], e[2*CH-1:CH], e[CH-1:0]);
            end
        end
    end

    initial begin
        for (int i = 0; i < CH; i++) begin
            per[i] = DP; start_edge[i] = 0; lvl[i] = 1'b0;
        end
        #1;
        tests++;
        if ({tick_any, tick_level, tick_pulse} !== '0) begin
            fails++;
            $display("FAIL reset_state: got %b required 0", {tick_any, tick_level, tick_pulse});
        end
        tick(2);
        reset = 1'b0;
        enable = 4'b0001;
        tick(16);
        wr(1, 3); enable[1] = 1'b1;
        tick(10);
        wr(1, 0);
        tick(6);
        wr(2, 1); enable[2] = 1'b1;
        tick(5);
        wr(2, 4);
        tick(4);
        wr(2, 6);
        tick(8);
        wr(15, 2);
        tick(3);
        wr(0, 5);
        tick(4);
        enable[0] = 1'b0;
        tick(4);
        enable[0] = 1'b1;
        tick(12);
`ifdef TICK_SYNC_EN
        wr(0, 4); tick(1);
        wr(3, 6); enable[3] = 1'b1; tick(7);
        sync = 1'b1;
        tick(14);
`endif
        tick(2);
        async_reset_check();
        tick(2);
        reset = 1'b0;
        tick(12);
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 15) == 0) enable[$urandom_range(0, CH-1)] ^= 1'b1;
            if ($urandom_range(0, 7) == 0) wr($urandom_range(0, 5) == 0 ? $urandom_range(4, 15) : $urandom_range(0, CH-1), $urandom_range(0, 7));
`ifdef TICK_SYNC_EN
            if ($urandom_range(0, 99) == 0) sync = 1'b1;
`endif
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 399) == 0) async_reset_check();
            tick(1);
        end
        @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/multi_tick_generator.md
# multi_tick_generator

Parametrised multi-channel timebase that produces periodic one-cycle strobes and 50 % square waves from the system clock. Each channel has its own run-time programmable period register, enable and counter. It replaces fixed, compile-time-period tick sources feeding the seven-segment display core (digit multiplexing, blink) and other slow-rate consumers with a single shared block.

## Interface
Parameters:
- CHANNELS, 4: number of independent tick channels (1..16).
- CNT_WIDTH, 32: width of period registers and counters.
- DEFAULT_PERIOD, 100000: period, in clk cycles, loaded into every channel at reset (must be < 2^CNT_WIDTH).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  CHANNELS  per-channel run enable, bit i controls channel i.
- wr_en  input  1  period write strobe, one cycle.
- wr_ch  input  4  target channel index for write.
- wr_period  input  CNT_WIDTH  new period in cycles.
- sync  input  1  phase-align all channels (present only with TICK_SYNC_EN).
- tick_pulse  output  CHANNELS  one-cycle strobe per expiry, registered.
- tick_level  output  CHANNELS  toggles at each expiry, registered.
- tick_any  output  1  registered OR of tick_pulse.

## Operation
- Per channel: period register P, counter C (CNT_WIDTH bits), registered pulse and level.
- Reset (async): C=0, P=DEFAULT_PERIOD, tick_pulse=0, tick_level=0, tick_any=0.
- Each rising edge, per channel, in priority order:
  - sync=1 (if compiled in): C<=0, pulse<=0, level<=0, for all channels.
  - wr_en=1 and wr_ch==i: P<=wr_period, C<=0, pulse<=0; level held. Write beats a coincident expiry (no pulse).
  - enable[i]=0 or P==0: C<=0, pulse<=0, level held.
  - C==P-1: C<=0, pulse<=1, level<=~level.
  - otherwise: C<=C+1, pulse<=0.
- wr_ch >= CHANNELS: write ignored, no state change.
- P==0: channel idle, never ticks. P==1: pulse high every enabled cycle, level toggles every cycle.
- Counter compare uses full CNT_WIDTH; P-1 never wraps since P==0 is handled first.
- tick_any registered from the next-state pulses, so aligned with tick_pulse.

## Timing
- Enable asserted before edge 1 and held: first pulse registered at edge P, high for exactly one cycle; subsequent pulses every P cycles.
- tick_level period = 2P cycles, 50 % duty.
- Write at edge k: new P active from edge k; first pulse at edge k+P (if enabled).
- Disabling mid-count discards the partial count; re-enable restarts from 0.
- Reset mid-operation: outputs drop to 0 asynchronously, P restored to DEFAULT_PERIOD.
- No combinational path from inputs to outputs.

## Configuration
- TICK_SYNC_EN defined: sync port exists and behaves as above, giving phase-coherent restart of all channels.
- Undefined: no sync port; channels only realign via reset or individual writes.

## Test plan
- Reset, DEFAULT_PERIOD=5, enable=4'b0001 -> tick_pulse[0] high one cycle at edges 5, 10, 15; tick_level[0] toggles at same edges; other channels stay 0.
- Write ch1 period 3 at edge 2 with enable[1]=1 -> pulses at edges 5, 8, 11; write ch1 period 0 -> no further pulses, level held.
- Ch2 period 1, enabled -> tick_pulse[2] constantly 1, tick_level[2] toggles every cycle; tick_any=1.
- Write to ch2 on the same edge its counter reaches P-1 -> no pulse that edge; next pulse P_new edges later. Write with wr_ch=15, CHANNELS=4 -> no change.
- Drop enable[0] at count 3 of period 5, re-raise 4 cycles later -> next pulse 5 edges after re-enable.
- With TICK_SYNC_EN: periods 4 and 6 running, pulse sync -> all counters and levels 0; pulses at sync+4 and sync+6 edges. Assert reset mid-count -> outputs 0 immediately, next pulse DEFAULT_PERIOD edges after release.
